// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - writeback request, bank write and forwarding signals
interface writeback_queue_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 2,
    parameter int DEPTH_LOG2    = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [0:ADDRESS_WIDTH-1] in_addr;
    logic [0:DATA_WIDTH-1]    in_data;
    logic                     stall;
    logic                     wr_en;
    logic [0:ADDRESS_WIDTH-1] wr_addr;
    logic [0:DATA_WIDTH-1]    wr_data;
    logic [0:ADDRESS_WIDTH-1] fwd_addr;
    logic                     fwd_hit;
    logic [0:DATA_WIDTH-1]    fwd_data;
    logic [0:DEPTH_LOG2]      count;
    logic                     empty;
    logic                     full;

    // Producer / bank / reader side
    modport master (
        output in_valid, in_addr, in_data, stall, fwd_addr,
        input  in_ready, wr_en, wr_addr, wr_data, fwd_hit, fwd_data, count, empty, full
    );

    // Queue side
    modport slave (
        input  in_valid, in_addr, in_data, stall, fwd_addr,
        output in_ready, wr_en, wr_addr, wr_data, fwd_hit, fwd_data, count, empty, full
    );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register writeback queue with forwarding lookup
module writeback_queue #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 2,
    parameter int DEPTH_LOG2    = 2
) (
    input logic          clk,
    input logic          reset,
    writeback_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [0:ADDRESS_WIDTH-1] addr_mem [DEPTH];
    logic [0:DATA_WIDTH-1]    data_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count_q;

    logic empty_w;
    logic full_w;
    logic push;
    logic pop;

    logic [DEPTH_LOG2-1:0]    idx;
    logic                     hit;
    logic [0:DATA_WIDTH-1]    hit_data;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    // in_ready only looks at occupancy, so a slot freed by a pop shows up next cycle
    assign push    = bus.in_valid && !full_w;
    assign pop     = !empty_w && !bus.stall;

    assign bus.in_ready = !full_w;
    assign bus.wr_en    = pop;
    assign bus.wr_addr  = empty_w ? '0 : addr_mem[head];
    assign bus.wr_data  = empty_w ? '0 : data_mem[head];
    assign bus.count    = count_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.fwd_hit  = hit;
    assign bus.fwd_data = hit_data;

    // Pointer and occupancy update; reset discards everything pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care outside the occupied window
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[tail] <= bus.in_addr;
            data_mem[tail] <= bus.in_data;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + DEPTH_LOG2'(i);
            if (((DEPTH_LOG2+1)'(i) < count_q) && (addr_mem[idx] == bus.fwd_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
    logic clk;
    logic reset;

    int vectors    = 0;
    int miscompares = 0;

    logic [9:0] exp_q [$];
    logic [7:0] bank [4];

    writeback_queue_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .DEPTH_LOG2(2)) bus ();

    writeback_queue #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // External register bank captures whatever the queue writes
    always @(posedge clk) begin
        if (bus.wr_en) bank[bus.wr_addr] <= bus.wr_data;
    end

    // Monitor: every bank write must match the next expected entry in push order
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("drain_addr", 32'(bus.wr_addr), 32'(e[9:8]));
                check("drain_data", 32'(bus.wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d, input bit expect_write);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        @(posedge clk);
        if (expect_write) exp_q.push_back({a, d});
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.stall    = 1'b0;
        bus.fwd_addr = '0;
        #3;
        check("reset_in_ready", 32'(bus.in_ready), 1);
        check("reset_wr_en",    32'(bus.wr_en), 0);
        check("reset_wr_addr",  32'(bus.wr_addr), 0);
        check("reset_wr_data",  32'(bus.wr_data), 0);
        check("reset_count",    32'(bus.count), 0);
        check("reset_empty",    32'(bus.empty), 1);
        check("reset_full",     32'(bus.full), 0);
        check("reset_fwd_hit",  32'(bus.fwd_hit), 0);
        check("reset_fwd_data", 32'(bus.fwd_data), 0);
        tick();
        reset = 1'b0;

        // 1. basic write-through
        push(2'd2, 8'hA5, 1'b1);
        check("t1_wr_en",   32'(bus.wr_en), 1);
        check("t1_wr_addr", 32'(bus.wr_addr), 2);
        check("t1_wr_data", 32'(bus.wr_data), 32'hA5);
        check("t1_count",   32'(bus.count), 1);
        tick();
        check("t1_empty", 32'(bus.empty), 1);
        check("t1_bank2", 32'(bank[2]), 32'hA5);

        // 2. fill and drain
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) push(2'(k), 8'(8'h10 + k), 1'b1);
        check("t2_full",     32'(bus.full), 1);
        check("t2_in_ready", 32'(bus.in_ready), 0);
        check("t2_count",    32'(bus.count), 4);
        push(2'd0, 8'hFF, 1'b0);
        check("t2_count_after_reject", 32'(bus.count), 4);
        bus.stall = 1'b0;
        #1;
        check("t2_wr_en_full",     32'(bus.wr_en), 1);
        check("t2_in_ready_pop",   32'(bus.in_ready), 0);
        check("t2_head_data",      32'(bus.wr_data), 32'h10);
        for (int k = 0; k < 4; k++) tick();
        check("t2_empty", 32'(bus.empty), 1);
        check("t2_queue_drained", 32'(exp_q.size()), 0);

        // 3. forwarding priority
        bus.stall = 1'b1;
        push(2'd1, 8'h22, 1'b1);
        push(2'd1, 8'h33, 1'b1);
        bus.fwd_addr = 2'd1;
        #1;
        check("t3_hit1",  32'(bus.fwd_hit), 1);
        check("t3_data1", 32'(bus.fwd_data), 32'h33);
        bus.fwd_addr = 2'd3;
        #1;
        check("t3_hit3",  32'(bus.fwd_hit), 0);
        check("t3_data3", 32'(bus.fwd_data), 0);
        bus.fwd_addr = 2'd1;
        bus.stall = 1'b0;
        tick();
        bus.stall = 1'b1;
        #1;
        check("t3_count_after_pop", 32'(bus.count), 1);
        check("t3_hit_after_pop",   32'(bus.fwd_hit), 1);
        check("t3_data_after_pop",  32'(bus.fwd_data), 32'h33);
        bus.stall = 1'b0;
        #1;
        check("t3_hit_popping_head", 32'(bus.fwd_hit), 1);
        check("t3_data_popping_head", 32'(bus.fwd_data), 32'h33);
        tick();
        check("t3_empty", 32'(bus.empty), 1);
        check("t3_hit_empty", 32'(bus.fwd_hit), 0);

        // 4. simultaneous push/pop across pointer wrap
        bus.stall = 1'b1;
        push(2'd3, 8'hE0, 1'b1);
        push(2'd3, 8'hE1, 1'b1);
        bus.stall = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'(k);
            bus.in_data  = 8'(k);
            @(posedge clk);
            exp_q.push_back({2'(k), 8'(k)});
            #1;
            check("t4_count_steady", 32'(bus.count), 2);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t4_empty", 32'(bus.empty), 1);
        check("t4_queue_drained", 32'(exp_q.size()), 0);

        // 5. async reset mid-operation
        bus.stall = 1'b1;
        push(2'd0, 8'h51, 1'b0);
        push(2'd1, 8'h52, 1'b0);
        push(2'd2, 8'h53, 1'b0);
        check("t5_count_pending", 32'(bus.count), 3);
        bus.fwd_addr = 2'd1;
        #2;
        reset = 1'b1;
        #1;
        check("t5_count",    32'(bus.count), 0);
        check("t5_empty",    32'(bus.empty), 1);
        check("t5_wr_en",    32'(bus.wr_en), 0);
        check("t5_fwd_hit",  32'(bus.fwd_hit), 0);
        check("t5_in_ready", 32'(bus.in_ready), 1);
        bus.stall    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr  = 2'd3;
        bus.in_data  = 8'h77;
        tick();
        check("t5_dropped_in_reset", 32'(bus.count), 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        push(2'd3, 8'h99, 1'b1);
        check("t5_first_push_count", 32'(bus.count), 1);
        check("t5_first_push_data",  32'(bus.wr_data), 32'h99);
        tick();
        tick();
        check("t5_final_empty", 32'(bus.empty), 1);
        check("t5_queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register writeback requests from the execute/memory stage and drains them, one per cycle, into the register bank's write port (`write`, `addr_in`, `data_in`). It also provides a forwarding lookup, so a reader of the bank can obtain the newest value still pending in the queue for a given register. This decouples producers from bank write availability without losing program order.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8, register data width; matches the register bank.
- `ADDRESS_WIDTH`, default 2, register address width; matches the register bank.
- `DEPTH_LOG2`, default 2, log2 of the queue depth (`DEPTH = 1<<DEPTH_LOG2`).

**Ports** (bit-vectors indexed `[0:W-1]`, bit 0 is the MSB)
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: a writeback request is present.
- `in_ready`, output, 1: the queue accepts a request this cycle.
- `in_addr`, input, `ADDRESS_WIDTH`: destination register.
- `in_data`, input, `DATA_WIDTH`: value to write.
- `stall`, input, 1: the bank write port is unavailable this cycle.
- `wr_en`, output, 1: drives the bank `write` input.
- `wr_addr`, output, `ADDRESS_WIDTH`: drives the bank `addr_in` input.
- `wr_data`, output, `DATA_WIDTH`: drives the bank `data_in` input.
- `fwd_addr`, input, `ADDRESS_WIDTH`: register being read (same as the bank `addr_out`).
- `fwd_hit`, output, 1: a pending entry targets `fwd_addr`.
- `fwd_data`, output, `DATA_WIDTH`: newest pending value for `fwd_addr`.
- `count`, output, `DEPTH_LOG2+1`: number of occupied entries, 0..DEPTH.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.

## Operation

**Storage**
- Circular buffer of DEPTH entries, each holding {addr, data}.
- `head` and `tail` pointers are `DEPTH_LOG2` bits wide and wrap modulo DEPTH.
- `count` is held in a separate register.

**Push and pop**
- Push condition: `in_valid && in_ready`. The entry is written at `tail`, and `tail` increments.
- `in_ready = !full`. It does not depend on a same-cycle pop.
- `wr_en = !empty && !stall`. `wr_addr` and `wr_data` show the head entry.
- When `empty`, `wr_addr` and `wr_data` are 0.
- Pop condition: `wr_en` high at the rising edge. `head` increments on pop.

**Count update**
- Push only: +1.
- Pop only: −1.
- Push and pop in the same cycle: unchanged.

**Order and overwrites**
- Entries drain strictly in push order.
- Duplicate addresses are allowed. Each entry is written to the bank in turn, so the last write wins.

**Forwarding** (combinational from queue state only; `in_*` in the same cycle are not visible)
- `fwd_hit` = 1 if any occupied entry has `addr == fwd_addr`.
- `fwd_data` = data of the youngest matching entry (closest to `tail`). It is 0 when there is no hit.
- The head entry being popped this cycle still counts as a hit. The bank holds the value only after the edge.

**Reset**
- Asserting `reset` immediately, asynchronously, clears `head`, `tail` and `count`. Any pending entries are discarded.
- While reset is asserted the outputs are: `in_ready=1`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `fwd_hit=0`, `fwd_data=0`, `count=0`, `empty=1`, `full=0`.
- Entry storage contents need not be cleared.
- A request presented while reset is high is dropped.

## Timing

- **Push to bank-write latency:** 1 cycle minimum. An entry pushed at edge N appears on `wr_*` with `wr_en=1` during cycle N+1, if `stall=0` and it is at head. The bank captures it at edge N+1.
- **Throughput:** 1 push and 1 pop per cycle sustained when `0 < count < DEPTH`.
- **Full:** `in_ready=0` for the whole cycle, even if a pop occurs. The freed slot is visible the next cycle.
- **Empty:** `wr_en=0`. A push does not bypass to `wr_*` in the same cycle.
- **`stall`:** takes effect combinationally on `wr_en`. The head entry is held stable on `wr_addr` and `wr_data` while stalled.
- **Reset deassertion:** the first push is accepted at the first rising edge after deassertion.

## Test plan

1. **Basic write-through.**
   - Stimulus: reset, then push (addr=2, data=0xA5) with `stall=0`.
   - Required: next cycle `wr_en=1`, `wr_addr=2`, `wr_data=0xA5`, `count=1`. After the following edge, `empty=1` and bank reg2 = 0xA5.
2. **Fill and drain.**
   - Stimulus: with `stall=1`, push (0,0x10), (1,0x11), (2,0x12), (3,0x13), then assert `in_valid` with (0,0xFF).
   - Required: `full=1`, `in_ready=0`, `count=4`. The 0xFF request is not accepted.
   - Then deassert `stall`: writes 0x10, 0x11, 0x12, 0x13 appear on consecutive cycles, then `empty=1`.
3. **Forwarding priority.**
   - Stimulus: with `stall=1`, push (1,0x22), then (1,0x33).
   - Required: `fwd_addr=1` gives `fwd_hit=1`, `fwd_data=0x33`. `fwd_addr=3` gives `fwd_hit=0`, `fwd_data=0`.
   - Then pop one entry: `fwd_data` remains 0x33.
4. **Simultaneous push/pop and wrap.**
   - Stimulus: hold `count=2` while pushing 10 sequential values 0x01..0x0A with `stall=0`.
   - Required: `count` stays 2 throughout. `wr_data` sequence matches push order across pointer wrap.
5. **Async reset mid-operation.**
   - Stimulus: with 3 entries pending and `stall=1`, assert `reset` between clock edges.
   - Required: immediately `count=0`, `empty=1`, `wr_en=0`, `fwd_hit=0`, `in_ready=1`. No bank write occurs afterwards.
